// File: rtl/adat_rx_adat_pkg.sv
// Shared types and defaults for the ADAT receive lock path.
//   SampleRate : classified/locked sample rate (Unknown when no valid rate)
//   LockState  : lock controller state, also exported for debug
//   DEF_*      : default nominal frame periods (in clk cycles) and lock tuning
//   within_tol : |frame_time - nominal| <= tol using 13-bit signed math
package adat_rx_adat_pkg;

  typedef enum logic [2:0] {
    Rate44_1kHz = 3'd0,
    Rate48kHz   = 3'd1,
    Rate88_2kHz = 3'd2,
    Rate96kHz   = 3'd3,
    Unknown     = 3'd4
  } SampleRate;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } LockState;

  localparam int DEF_NOM_48K        = 2048;
  localparam int DEF_NOM_44K1       = 2229;
  localparam int DEF_NOM_96K        = 1024;
  localparam int DEF_NOM_88K2       = 1114;
  localparam int DEF_TOL            = 16;
  localparam int DEF_LOCK_FRAMES    = 4;
  localparam int DEF_UNLOCK_FRAMES  = 3;
  localparam int DEF_TIMEOUT_CYCLES = 8192;

  // The 12-bit period is zero-extended into 13 signed bits so the difference
  // against any nominal below 4096 cannot wrap.
  function automatic logic within_tol(input logic [11:0] frame_time,
                                      input int nom,
                                      input int tol);
    logic signed [12:0] diff;
    logic signed [12:0] lim;
    diff = $signed({1'b0, frame_time}) - $signed(13'(nom));
    lim  = $signed(13'(tol));
    return (diff >= -lim) && (diff <= lim);
  endfunction

endpackage

// File: rtl/adat_rx_rate_classifier.sv
// Combinational frame-period classifier.
// Ports:
//   frame_time : measured frame period in clk cycles
//   sync       : sync pattern seen for this frame
//   rate       : matched sample rate, Unknown unless the frame is good
//   good       : sync present and period within tolerance of exactly one rate
module adat_rx_rate_classifier
  import adat_rx_adat_pkg::*;
#(
  parameter int NOM_48K  = DEF_NOM_48K,
  parameter int NOM_44K1 = DEF_NOM_44K1,
  parameter int NOM_96K  = DEF_NOM_96K,
  parameter int NOM_88K2 = DEF_NOM_88K2,
  parameter int TOL      = DEF_TOL
) (
  input  logic [11:0] frame_time,
  input  logic        sync,
  output SampleRate   rate,
  output logic        good
);

  logic [3:0] hits;

  // Window test against every nominal; only a single unambiguous hit is a rate.
  always_comb begin
    hits    = 4'b0000;
    hits[0] = within_tol(frame_time, NOM_44K1, TOL);
    hits[1] = within_tol(frame_time, NOM_48K,  TOL);
    hits[2] = within_tol(frame_time, NOM_88K2, TOL);
    hits[3] = within_tol(frame_time, NOM_96K,  TOL);
    rate    = Unknown;
    good    = 1'b0;
    if (sync) begin
      case (hits)
        4'b0001: rate = Rate44_1kHz;
        4'b0010: rate = Rate48kHz;
        4'b0100: rate = Rate88_2kHz;
        4'b1000: rate = Rate96kHz;
        default: rate = Unknown;
      endcase
    end else begin
      rate = Unknown;
    end
    if (rate != Unknown) begin
      good = 1'b1;
    end else begin
      good = 1'b0;
    end
  end

endmodule

// File: rtl/adat_rx_lock_controller.sv
// ADAT receive lock controller: acquires, holds and drops lock from per-frame
// period measurements, with hysteresis and a no-frame timeout.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_frame_time   : measured frame period, sampled with i_frame_valid
//   i_frame_valid  : one-cycle strobe per received frame
//   i_sync         : sync pattern detected, sampled with i_frame_valid
//   o_sample_rate  : locked rate, Unknown when unlocked
//   o_locked       : lock status
//   o_mute         : output stage must withhold audio
//   o_rate_change  : one-cycle pulse when locking to a rate different from the last one
//   o_state        : current LockState for debug
// All outputs are registered and reflect a strobe one cycle after it.
module adat_rx_lock_controller
  import adat_rx_adat_pkg::*;
#(
  parameter int NOM_48K        = DEF_NOM_48K,
  parameter int NOM_44K1       = DEF_NOM_44K1,
  parameter int NOM_96K        = DEF_NOM_96K,
  parameter int NOM_88K2       = DEF_NOM_88K2,
  parameter int TOL            = DEF_TOL,
  parameter int LOCK_FRAMES    = DEF_LOCK_FRAMES,
  parameter int UNLOCK_FRAMES  = DEF_UNLOCK_FRAMES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_frame_time,
  input  logic        i_frame_valid,
  input  logic        i_sync,
  output SampleRate   o_sample_rate,
  output logic        o_locked,
  output logic        o_mute,
  output logic        o_rate_change,
  output logic [1:0]  o_state
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int BW = $clog2(UNLOCK_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  LockState        state;
  SampleRate       cand;
  SampleRate       last_rate;
  logic [GW-1:0]   good_cnt;
  logic [BW-1:0]   bad_cnt;
  logic [TW-1:0]   tmo_cnt;
  SampleRate       frame_rate;
  logic            frame_good;
  logic            tmo_expired;
  logic            rate_match;

  adat_rx_rate_classifier #(
    .NOM_48K  (NOM_48K),
    .NOM_44K1 (NOM_44K1),
    .NOM_96K  (NOM_96K),
    .NOM_88K2 (NOM_88K2),
    .TOL      (TOL)
  ) u_classifier (
    .frame_time (i_frame_time),
    .sync       (i_sync),
    .rate       (frame_rate),
    .good       (frame_good)
  );

  assign tmo_expired = (tmo_cnt == TW'(TIMEOUT_CYCLES));
  // While LOCKED/HOLDOVER the output rate register is the locked rate.
  assign rate_match  = frame_good && (frame_rate == o_sample_rate);
  assign o_state     = state;

  // Lock FSM, hysteresis counters, timeout counter and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= UNLOCKED;
      cand          <= Unknown;
      last_rate     <= Unknown;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      tmo_cnt       <= '0;
      o_locked      <= 1'b0;
      o_mute        <= 1'b1;
      o_sample_rate <= Unknown;
      o_rate_change <= 1'b0;
    end else begin
      o_rate_change <= 1'b0;

      // Saturating count of cycles since the last strobe.
      if (i_frame_valid) begin
        tmo_cnt <= '0;
      end else if (!tmo_expired) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= tmo_cnt;
      end

      // A strobe on the expiry cycle takes priority over the timeout.
      if (i_frame_valid) begin
        case (state)
          UNLOCKED: begin
            if (frame_good) begin
              state    <= ACQUIRE;
              cand     <= frame_rate;
              good_cnt <= GW'(1);
            end else begin
              state    <= UNLOCKED;
            end
          end

          ACQUIRE: begin
            if (!frame_good) begin
              state    <= UNLOCKED;
              cand     <= Unknown;
              good_cnt <= '0;
            end else if (frame_rate != cand) begin
              cand     <= frame_rate;
              good_cnt <= GW'(1);
            end else if (good_cnt >= GW'(LOCK_FRAMES - 1)) begin
              state         <= LOCKED;
              good_cnt      <= '0;
              bad_cnt       <= '0;
              o_sample_rate <= cand;
              o_locked      <= 1'b1;
              o_mute        <= 1'b0;
              o_rate_change <= (cand != last_rate);
              last_rate     <= cand;
            end else begin
              good_cnt <= good_cnt + GW'(1);
            end
          end

          LOCKED: begin
            if (rate_match) begin
              state   <= LOCKED;
            end else begin
              state   <= HOLDOVER;
              bad_cnt <= BW'(1);
              o_mute  <= 1'b1;
            end
          end

          HOLDOVER: begin
            if (rate_match) begin
              state   <= LOCKED;
              bad_cnt <= '0;
              o_mute  <= 1'b0;
            end else if (bad_cnt >= BW'(UNLOCK_FRAMES - 1)) begin
              state         <= UNLOCKED;
              cand          <= Unknown;
              good_cnt      <= '0;
              bad_cnt       <= '0;
              o_locked      <= 1'b0;
              o_mute        <= 1'b1;
              o_sample_rate <= Unknown;
            end else begin
              bad_cnt <= bad_cnt + BW'(1);
            end
          end

          default: begin
            state         <= UNLOCKED;
            cand          <= Unknown;
            good_cnt      <= '0;
            bad_cnt       <= '0;
            o_locked      <= 1'b0;
            o_mute        <= 1'b1;
            o_sample_rate <= Unknown;
          end
        endcase
      end else if (tmo_expired && (state != UNLOCKED)) begin
        state         <= UNLOCKED;
        cand          <= Unknown;
        good_cnt      <= '0;
        bad_cnt       <= '0;
        o_locked      <= 1'b0;
        o_mute        <= 1'b1;
        o_sample_rate <= Unknown;
      end else begin
        state <= state;
      end
    end
  end

endmodule

// File: tb/tb_adat_rx_lock_controller.sv
// Scoreboard bench for adat_rx_lock_controller: each stimulus step queues the
// output it should produce one cycle later; a monitor pops and compares.
module tb_adat_rx_lock_controller;
  import adat_rx_adat_pkg::*;

  typedef struct {
    logic       locked;
    logic       mute;
    SampleRate  rate;
    logic       rc;
    logic [1:0] st;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] frame_time = 12'd0;
  logic        frame_valid = 1'b0;
  logic        sync = 1'b0;
  logic        chk = 1'b0;
  logic        pend = 1'b0;
  SampleRate   sample_rate;
  logic        locked;
  logic        mute;
  logic        rate_change;
  logic [1:0]  state;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  adat_rx_lock_controller dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_time  (frame_time),
    .i_frame_valid (frame_valid),
    .i_sync        (sync),
    .o_sample_rate (sample_rate),
    .o_locked      (locked),
    .o_mute        (mute),
    .o_rate_change (rate_change),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic l, input logic m, input SampleRate r,
                              input logic c, input logic [1:0] s, input string n);
    exp_t e;
    e.locked = l; e.mute = m; e.rate = r; e.rc = c; e.st = s; e.name = n;
    return e;
  endfunction

  // All tasks are entered on a negedge and return on a negedge.
  task automatic frame(input logic [11:0] t, input logic s, input exp_t e);
    frame_time  = t;
    sync        = s;
    frame_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic check_now(input exp_t e);
    chk = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    chk = 1'b0;
  endtask

  // Output event: a strobe or explicit check was present on the last edge.
  always @(posedge clk) pend <= frame_valid | chk;

  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: output event with no expectation queued");
      end else begin
        e = sb.pop_front();
        if ({locked, mute, sample_rate, rate_change, state} !== {e.locked, e.mute, e.rate, e.rc, e.st}) begin
          n_fail++;
          $display("FAIL %s: got locked=%0b mute=%0b rate=%s rc=%0b state=%0d, expected locked=%0b mute=%0b rate=%s rc=%0b state=%0d",
                   e.name, locked, mute, sample_rate.name(), rate_change, state,
                   e.locked, e.mute, e.rate.name(), e.rc, e.st);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t rst_e, acq_e, l48, h48, ul;
    rst_e = mk(1'b0, 1'b1, Unknown,   1'b0, 2'd0, "reset");
    acq_e = mk(1'b0, 1'b1, Unknown,   1'b0, 2'd1, "acquire");
    l48   = mk(1'b1, 1'b0, Rate48kHz, 1'b0, 2'd2, "locked48");
    h48   = mk(1'b1, 1'b1, Rate48kHz, 1'b0, 2'd3, "holdover48");
    ul    = mk(1'b0, 1'b1, Unknown,   1'b0, 2'd0, "unlocked");

    repeat (3) @(negedge clk);
    check_now(rst_e);
    rst = 1'b0;
    check_now(rst_e);

    // Basic 48k lock, rate_change pulses once.
    for (int i = 0; i < 3; i++) frame(12'd2048, 1'b1, acq_e);
    frame(12'd2048, 1'b1, mk(1'b1, 1'b0, Rate48kHz, 1'b1, 2'd2, "lock48_pulse"));
    frame(12'd2048, 1'b1, l48);

    // Single off-period frame -> holdover, then recovery without pulse.
    frame(12'd2100, 1'b1, h48);
    frame(12'd2048, 1'b1, l48);

    // Tolerance edges while locked.
    frame(12'd2032, 1'b1, mk(1'b1, 1'b0, Rate48kHz, 1'b0, 2'd2, "edge_2032"));
    frame(12'd2064, 1'b1, mk(1'b1, 1'b0, Rate48kHz, 1'b0, 2'd2, "edge_2064"));
    frame(12'd2031, 1'b1, mk(1'b1, 1'b1, Rate48kHz, 1'b0, 2'd3, "edge_2031"));
    frame(12'd2048, 1'b1, l48);
    frame(12'd2065, 1'b1, mk(1'b1, 1'b1, Rate48kHz, 1'b0, 2'd3, "edge_2065"));
    frame(12'd2048, 1'b1, l48);

    // Three frames without sync -> unlock.
    frame(12'd2048, 1'b0, h48);
    frame(12'd2048, 1'b0, h48);
    frame(12'd2048, 1'b0, mk(1'b0, 1'b1, Unknown, 1'b0, 2'd0, "nosync_unlock"));

    // Candidate restart 48k -> 44.1k.
    frame(12'd2048, 1'b1, acq_e);
    frame(12'd2048, 1'b1, acq_e);
    for (int i = 0; i < 3; i++) frame(12'd2229, 1'b1, acq_e);
    frame(12'd2229, 1'b1, mk(1'b1, 1'b0, Rate44_1kHz, 1'b1, 2'd2, "lock44_pulse"));

    // Valid 96k frames are a mismatch while locked at 44.1k.
    frame(12'd1024, 1'b1, mk(1'b1, 1'b1, Rate44_1kHz, 1'b0, 2'd3, "mismatch1"));
    frame(12'd1024, 1'b1, mk(1'b1, 1'b1, Rate44_1kHz, 1'b0, 2'd3, "mismatch2"));
    frame(12'd1024, 1'b1, mk(1'b0, 1'b1, Unknown, 1'b0, 2'd0, "mismatch_unlock"));

    // Tolerance edges while unlocked, then relock at 48k with a pulse.
    frame(12'd2031, 1'b1, mk(1'b0, 1'b1, Unknown, 1'b0, 2'd0, "ul_2031"));
    frame(12'd2065, 1'b1, mk(1'b0, 1'b1, Unknown, 1'b0, 2'd0, "ul_2065"));
    frame(12'd2032, 1'b1, mk(1'b0, 1'b1, Unknown, 1'b0, 2'd1, "ul_2032"));
    frame(12'd2064, 1'b1, acq_e);
    frame(12'd2048, 1'b1, acq_e);
    frame(12'd2040, 1'b1, mk(1'b1, 1'b0, Rate48kHz, 1'b1, 2'd2, "relock48_pulse"));

    // Timeout: still locked after 8192 idle cycles, unlocked one cycle later.
    repeat (8191) @(negedge clk);
    check_now(mk(1'b1, 1'b0, Rate48kHz, 1'b0, 2'd2, "pre_timeout"));
    check_now(mk(1'b0, 1'b1, Unknown, 1'b0, 2'd0, "timeout_unlock"));

    // Relock with gaps; last_rate survives unlock so no pulse.
    for (int i = 0; i < 3; i++) begin
      frame(12'd2048, 1'b1, acq_e);
      repeat (3) @(negedge clk);
    end
    frame(12'd2048, 1'b1, mk(1'b1, 1'b0, Rate48kHz, 1'b0, 2'd2, "relock_no_pulse"));

    // Strobe exactly on the expiry cycle keeps the lock.
    repeat (8191) @(negedge clk);
    check_now(mk(1'b1, 1'b0, Rate48kHz, 1'b0, 2'd2, "pre_expiry"));
    frame(12'd2048, 1'b1, mk(1'b1, 1'b0, Rate48kHz, 1'b0, 2'd2, "strobe_on_expiry"));
    repeat (100) @(negedge clk);
    check_now(mk(1'b1, 1'b0, Rate48kHz, 1'b0, 2'd2, "after_expiry_frame"));

    // Unlock, then reset mid-ACQUIRE at 88.2k, coinciding with the locking frame.
    frame(12'd2048, 1'b0, h48);
    frame(12'd2048, 1'b0, h48);
    frame(12'd2048, 1'b0, ul);
    for (int i = 0; i < 3; i++) frame(12'd1114, 1'b1, acq_e);
    rst = 1'b1;
    frame(12'd1114, 1'b1, mk(1'b0, 1'b1, Unknown, 1'b0, 2'd0, "reset_mid_acquire"));
    rst = 1'b0;
    check_now(mk(1'b0, 1'b1, Unknown, 1'b0, 2'd0, "after_reset"));

    // Reset clears last_rate: a 96k lock pulses.
    for (int i = 0; i < 3; i++) frame(12'd1024, 1'b1, acq_e);
    frame(12'd1024, 1'b1, mk(1'b1, 1'b0, Rate96kHz, 1'b1, 2'd2, "lock96_pulse"));
    frame(12'd1024, 1'b1, mk(1'b1, 1'b0, Rate96kHz, 1'b0, 2'd2, "locked96"));

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
